// File: rtl/circular_fifo.sv
// Circular-buffer FIFO with payload storage, asynchronous head read and a DEPTH+1-state occupancy count.
// Status flags are registered from next-count; overflow/underflow are sticky until reset.
module circular_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4,
  parameter int ALMOST_MARGIN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(DEPTH - ALMOST_MARGIN);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  valid_q, full_q, afull_q, ovf_q, unf_q;
  logic                  ovf_d, unf_d;
  logic                  push_acc, pop_acc;

  // A pop on a full FIFO frees the slot the same cycle, so a simultaneous push is taken.
  assign pop_acc  = pop & valid_q;
  assign push_acc = push & (~full_q | pop_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_acc && !pop_acc)      count_d = count_q + CW'(1);
    else if (pop_acc && !push_acc) count_d = count_q - CW'(1);
    ovf_d = ovf_q | (push & full_q & ~pop);
    unf_d = unf_q | (pop & ~valid_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      full_q   <= (count_d == DEPTH_C);
      afull_q  <= (count_d >= AFULL_C);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_acc && !rst) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q == (full_q ? DEPTH_C : {1'b0, wr_ptr_q - rd_ptr_q}))
        else $error("circular_fifo: count/pointer mismatch");
    end
  end

  assign data_out    = mem_q[rd_ptr_q];
  assign valid       = valid_q;
  assign empty       = ~valid_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule
